seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 151 +++++++++++++++
 tb/tb_seq_alu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic ops, WIDTH-step shift-add multiply and restoring divide.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise op 111 reports an error immediately.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               out_zero,
  output logic               out_err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
                         OP_XOR = 3'b100, OP_NOT = 3'b101, OP_MUL = 3'b110, OP_DIV = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q;
  logic                 in_ready_q, out_valid_q, err_q;
  logic [2*WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]     opnd_q;
  logic [2*WIDTH:0]     acc_q;   // {hi(W+1), lo(W)}: product/multiplier or remainder/quotient
  logic [CW-1:0]        cnt_q;
`ifdef SEQ_ALU_DIV_EN
  logic                 is_div_q;
`endif

  logic [2*WIDTH-1:0]   fast_res_d;
  logic                 fast_err_d, start_seq_d;
  logic [WIDTH-1:0]     opnd_d, lo_d;
  logic [WIDTH:0]       mul_sum_d;
  logic [2*WIDTH:0]     mul_next_d, step_d;

  always_comb begin
    fast_res_d  = '0;
    fast_err_d  = 1'b0;
    start_seq_d = 1'b0;
    opnd_d      = in_a;
    lo_d        = in_b;
    case (in_op)
      OP_ADD: fast_res_d = (2*WIDTH)'(in_a) + (2*WIDTH)'(in_b);
      OP_SUB: fast_res_d = (2*WIDTH)'(in_a) - (2*WIDTH)'(in_b);
      OP_AND: fast_res_d = {{WIDTH{1'b0}}, in_a & in_b};
      OP_OR:  fast_res_d = {{WIDTH{1'b0}}, in_a | in_b};
      OP_XOR: fast_res_d = {{WIDTH{1'b0}}, in_a ^ in_b};
      OP_NOT: fast_res_d = {~in_b, ~in_a};
      OP_MUL: start_seq_d = 1'b1;
      OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
        opnd_d = in_b;
        lo_d   = in_a;
        if (in_b != '0) start_seq_d = 1'b1;
        else            fast_err_d  = 1'b1;
`else
        fast_err_d = 1'b1;
`endif
      end
      default: fast_err_d = 1'b1;
    endcase
  end

  // Shift-add: add multiplicand into the high half when the multiplier LSB is set, then shift right.
  always_comb begin
    mul_sum_d  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next_d = {1'b0, mul_sum_d, acc_q[WIDTH-1:1]};
    step_d     = mul_next_d;
  end

`ifdef SEQ_ALU_DIV_EN
  logic [2*WIDTH:0] div_sh_d, div_next_d;
  logic [WIDTH:0]   div_trial_d;
  // Restoring step: shift in the next dividend bit, keep the subtraction only if it does not borrow.
  always_comb begin
    div_sh_d    = {acc_q[2*WIDTH-1:0], 1'b0};
    div_trial_d = div_sh_d[2*WIDTH:WIDTH] - {1'b0, opnd_q};
    div_next_d  = div_sh_d;
    if (div_sh_d[2*WIDTH:WIDTH] >= {1'b0, opnd_q})
      div_next_d = {div_trial_d, div_sh_d[WIDTH-1:1], 1'b1};
    if (is_div_q) step_d = div_next_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      res_q       <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`ifdef SEQ_ALU_DIV_EN
      is_div_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          in_ready_q <= 1'b0;
          if (start_seq_d) begin
            state_q <= BUSY;
            cnt_q   <= '0;
            opnd_q  <= opnd_d;
            acc_q   <= {{(WIDTH+1){1'b0}}, lo_d};
`ifdef SEQ_ALU_DIV_EN
            is_div_q <= (in_op == OP_DIV);
`endif
          end else begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            res_q       <= fast_res_d;
            err_q       <= fast_err_d;
          end
        end
        BUSY: begin
          acc_q <= step_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            res_q       <= step_d[2*WIDTH-1:0];
            err_q       <= 1'b0;
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_err    = err_q;
  assign out_zero   = out_valid_q & (res_q == '0);
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=8; expectations follow the SEQ_ALU_DIV_EN build setting.
module tb_seq_alu;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready, out_zero, out_err;
  logic [W-1:0]  in_a, in_b;
  logic [2:0]    in_op;
  logic [2*W-1:0] out_result;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    exp_t e;
    e.res = 16'h0; e.err = 1'b0; e.lat = 1;
    case (op)
      3'd0: e.res = {8'h00, a} + {8'h00, b};
      3'd1: e.res = {8'h00, a} - {8'h00, b};
      3'd2: e.res = {8'h00, a & b};
      3'd3: e.res = {8'h00, a | b};
      3'd4: e.res = {8'h00, a ^ b};
      3'd5: e.res = {~b, ~a};
      3'd6: begin e.res = {8'h00, a} * {8'h00, b}; e.lat = 9; end
      default: begin
`ifdef SEQ_ALU_DIV_EN
        if (b == 8'h00) e.err = 1'b1;
        else begin
          e.res = {a % b, a / b};
          e.lat = 9;
        end
`else
        e.err = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  // Drive one op, score it, optionally hold out_ready low for `hold` cycles with a stray in_valid pulse.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input int hold, output logic [15:0] got, output int lat);
    exp_t e;
    int   n;
    bit   busy_ok;
    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (!in_ready) begin errors++; $display("FAIL ready_wait: in_ready=%b required 1", in_ready); end
    sb.push_back(model(a, b, op));
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    got = out_result;
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL busy_ready: in_ready seen 1 before result, op=%0d", op); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL timeout: out_valid=%b after %0d cycles", out_valid, lat); end
    checks++;
    if (out_result !== e.res) begin errors++; $display("FAIL result op=%0d a=%0d b=%0d: got %h required %h", op, a, b, out_result, e.res); end
    checks++;
    if (out_err !== e.err) begin errors++; $display("FAIL err op=%0d: got %b required %b", op, out_err, e.err); end
    checks++;
    if (out_zero !== (e.res == 16'h0)) begin errors++; $display("FAIL zero op=%0d: got %b required %b", op, out_zero, (e.res == 16'h0)); end
    checks++;
    if (lat != e.lat) begin errors++; $display("FAIL latency op=%0d: got %0d required %0d", op, lat, e.lat); end
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 1);
      in_op = 3'd0; in_a = 8'h11; in_b = 8'h22;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== e.res || out_err !== e.err || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc %0d: valid=%b res=%h ready=%b required valid=1 res=%h ready=0", i, out_valid, out_result, in_ready, e.res);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL release: valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 16'h0 || out_zero !== 1'b0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b res=%h zero=%b err=%b required 1 0 0000 0 0", in_ready, out_valid, out_result, out_zero, out_err);
    end
  endtask

  task automatic test_logic_ops();
    logic [15:0] got; int lat;
    run_op(8'd200, 8'd100, 3'd0, 0, got, lat);
    checks++;
    if (got !== 16'h012C || lat != 1) begin errors++; $display("FAIL add_200_100: got %h lat %0d required 012c lat 1", got, lat); end
    run_op(8'd2, 8'd5, 3'd1, 0, got, lat);
    checks++;
    if (got !== 16'hFFFD) begin errors++; $display("FAIL sub_2_5: got %h required fffd", got); end
    run_op(8'hF0, 8'h0F, 3'd3, 0, got, lat);
    run_op(8'h5A, 8'h5A, 3'd4, 0, got, lat);
    run_op(8'h12, 8'h34, 3'd5, 0, got, lat);
    checks++;
    if (got !== 16'hCBED) begin errors++; $display("FAIL not: got %h required cbed", got); end
    run_op(8'hFF, 8'hFF, 3'd0, 0, got, lat);
  endtask

  task automatic test_mul();
    logic [15:0] got; int lat;
    run_op(8'd255, 8'd255, 3'd6, 0, got, lat);
    checks++;
    if (got !== 16'hFE01 || lat != 9) begin errors++; $display("FAIL mul_255: got %h lat %0d required fe01 lat 9", got, lat); end
    run_op(8'd0, 8'd77, 3'd6, 0, got, lat);
    run_op(8'd13, 8'd1, 3'd6, 0, got, lat);
  endtask

  task automatic test_div();
    logic [15:0] got; int lat;
    run_op(8'd200, 8'd7, 3'd7, 0, got, lat);
`ifdef SEQ_ALU_DIV_EN
    checks++;
    if (got !== 16'h041C || lat != 9) begin errors++; $display("FAIL div_200_7: got %h lat %0d required 041c lat 9", got, lat); end
`else
    checks++;
    if (got !== 16'h0000 || lat != 1) begin errors++; $display("FAIL div_disabled: got %h lat %0d required 0000 lat 1", got, lat); end
`endif
    run_op(8'd9, 8'd0, 3'd7, 0, got, lat);
    checks++;
    if (got !== 16'h0000 || lat != 1) begin errors++; $display("FAIL div_by_zero: got %h lat %0d required 0000 lat 1", got, lat); end
    run_op(8'd255, 8'd1, 3'd7, 0, got, lat);
    run_op(8'd5, 8'd255, 3'd7, 0, got, lat);
  endtask

  task automatic test_backpressure();
    logic [15:0] got; int lat;
    run_op(8'hF0, 8'h3C, 3'd2, 5, got, lat);
    checks++;
    if (got !== 16'h0030) begin errors++; $display("FAIL and_bp: got %h required 0030", got); end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL stray_accept: out_valid=%b required 0", out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got; int lat;
    in_a = 8'd255; in_b = 8'd255; in_op = 3'd6; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_busy: in_ready=%b required 0", in_ready); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 16'h0 || in_ready !== 1'b1 || out_err !== 1'b0) begin
      errors++; $display("FAIL mid_reset: valid=%b res=%h ready=%b required 0 0000 1", out_valid, out_result, in_ready);
    end
    repeat (12) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL partial_result: out_valid=%b required 0", out_valid); end
    end
    run_op(8'hAA, 8'hFF, 3'd4, 0, got, lat);
    checks++;
    if (got !== 16'h0055) begin errors++; $display("FAIL xor_after_reset: got %h required 0055", got); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got; int lat;
    logic [7:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      if (i % 6 == 5) b = 8'h00;
      run_op(a, b, 3'(i % 8), int'($urandom_range(0, 2)), got, lat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_logic_ops();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
